audio_note_seq: RTL and testbench
=================================

AUDIO_NOTE_SEQ -- requirements
Module: audio_note_seq

Interface
REQ-001 Parameter TICK_DIV, default 25000, clock cycles per duration tick; legal range 2..2^20.
REQ-002 Parameter GAP_CYCLES, default 256, silent cycles inserted after every note; legal range 1..2^16.
REQ-003 clk_i  input  1  single clock; all state on rising edge.
REQ-004 rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  begin playback from entry 0; level sampled each cycle.
REQ-006 stop_i  input  1  abort playback.
REQ-007 seq_len_i  input  5  number of entries to play; sampled on accepted start.
REQ-008 wr_en_i  input  1  note-table write strobe.
REQ-009 wr_addr_i  input  4  note-table write address (16 entries).
REQ-010 wr_data_i  input  20  entry {dur[3:0], freq[15:0]}; freq 0 = rest.
REQ-011 freq_o  output  16  phase increment for the downstream square generator's freq input.
REQ-012 gate_o  output  1  high while a non-rest note sounds.
REQ-013 busy_o  output  1  high in PLAY or GAP.
REQ-014 done_o  output  1  one-cycle pulse at natural end of sequence.
REQ-015 cur_idx_o  output  4  index of entry currently playing.

Function
REQ-016 States SHALL be IDLE, PLAY, GAP; IDLE after reset.
REQ-017 Note table SHALL be 16x20 flops, written on wr_en_i at any time; a write to the playing entry takes effect only at its next fetch.
REQ-018 IDLE + start_i + !stop_i + seq_len_i>0 -> next edge: PLAY, cur_idx_o=0, freq_o=entry0.freq, gate_o=(freq!=0), busy_o=1, tick divider and tick count cleared.
REQ-019 seq_len_i values 17..31 SHALL clamp to 16.
REQ-020 seq_len_i=0 on start SHALL not enter PLAY; done_o pulses on the next cycle.
REQ-021 In PLAY a tick SHALL occur every TICK_DIV cycles; after dur+1 ticks -> GAP with freq_o=0, gate_o=0.
REQ-022 GAP SHALL last exactly GAP_CYCLES cycles; total per note = (dur+1)*TICK_DIV + GAP_CYCLES cycles.
REQ-023 End of GAP with further entries -> PLAY, cur_idx_o+1, new entry fetched, counters cleared.
REQ-024 End of GAP on last entry -> IDLE, busy_o=0, cur_idx_o=0, done_o=1 for that one cycle.
REQ-025 stop_i in any state -> IDLE next edge, freq_o=0, gate_o=0, busy_o=0, no done_o pulse.
REQ-026 start_i while busy_o=1 SHALL be ignored; start_i and stop_i together -> stop wins.
REQ-027 freq_o and gate_o SHALL be registered, stable for the whole PLAY interval.

Reset
REQ-028 rstn_i low SHALL immediately force IDLE, freq_o=0, gate_o=0, busy_o=0, done_o=0, cur_idx_o=0, all counters 0.
REQ-029 Note-table contents SHALL reset to all zeros.
REQ-030 Reset asserted mid-note SHALL silence output without completing the note or pulsing done_o.

Configuration
REQ-031 Macro AUDIO_SEQ_LOOP_EN defined: end of GAP on last entry SHALL wrap to entry 0 in PLAY (re-fetch), busy_o stays 1, done_o never pulses; only stop_i or reset ends playback.
REQ-032 AUDIO_SEQ_LOOP_EN undefined: sequence plays once per REQ-024.

Verification (TICK_DIV=4, GAP_CYCLES=2)
REQ-033 Write entry0={1,16'h0100}, entry1={0,16'h0200}, start len=2 -> freq_o 0x0100 for 8 cycles, 0 for 2, 0x0200 for 4, 0 for 2, done_o pulse, busy_o low.
REQ-034 Entry0={0,16'h0000} rest, len=1 -> gate_o stays 0 for 4 cycles, freq_o 0, done_o after 6 cycles total.
REQ-035 stop_i mid-PLAY of entry 0 -> next cycle freq_o=0, busy_o=0, no done_o; restart then plays entry 0 from full duration.
REQ-036 start len=0 -> busy_o stays 0, done_o pulses one cycle later; start len=20 -> 16 entries played.
REQ-037 start_i held high throughout playback and start+stop same cycle -> no restart, stop wins.
REQ-038 AUDIO_SEQ_LOOP_EN defined, len=2 -> entry 0 replays after entry 1 GAP, done_o never asserts; rstn_i low mid-note -> all outputs 0 immediately.

Source files
------------

// File: rtl/audio_note_seq.sv
// audio_note_seq -- plays a 16-entry note table as a timed sequence of
// phase increments for a downstream square-wave generator.
//
// Each entry is {dur[3:0], freq[15:0]}; freq 0 is a rest. An entry sounds
// for (dur+1)*TICK_DIV cycles, followed by GAP_CYCLES of silence.
//
// Ports:
//   clk_i      clock, all state on rising edge
//   rstn_i     asynchronous active-low reset
//   start_i    begin playback from entry 0 (ignored while busy)
//   stop_i     abort playback (wins over start_i)
//   seq_len_i  number of entries to play (17..31 clamp to 16)
//   wr_en_i    note-table write strobe
//   wr_addr_i  note-table write address
//   wr_data_i  note-table write data {dur, freq}
//   freq_o     registered phase increment, 0 when silent
//   gate_o     high while a non-rest note sounds
//   busy_o     high in PLAY or GAP
//   done_o     one-cycle pulse at natural end of the sequence
//   cur_idx_o  index of the entry currently playing
//
// Configuration macro: AUDIO_SEQ_LOOP_EN -- when defined, the sequence wraps
// to entry 0 after the last gap instead of finishing.
module audio_note_seq #(
    parameter int TICK_DIV   = 25000,
    parameter int GAP_CYCLES = 256
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic [4:0]  seq_len_i,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_addr_i,
    input  logic [19:0] wr_data_i,
    output logic [15:0] freq_o,
    output logic        gate_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [3:0]  cur_idx_o
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [19:0] DIV_LAST = 20'(TICK_DIV - 1);
    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [19:0] note_tbl [16];
    logic [4:0]  len_q, len_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  dur_q, dur_d;
    logic [19:0] div_q, div_d;
    logic [3:0]  tick_q, tick_d;
    logic [15:0] gap_q, gap_d;
    logic [15:0] freq_q, freq_d;
    logic        gate_q, gate_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic        last_entry;
    logic        load;
    logic [3:0]  fetch_idx;
    logic [19:0] fetch_entry;

    assign last_entry  = ({1'b0, idx_q} == (len_q - 5'd1));
    // Only a mid-sequence gap advances; every other fetch is entry 0.
    assign fetch_idx   = (state_q == GAP && !last_entry) ? idx_q + 4'd1 : 4'd0;
    assign fetch_entry = note_tbl[fetch_idx];

    // Note table: writes land at any time; the playing note holds its own
    // copy of freq/dur so a write only shows up on the next fetch.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 16; i++) note_tbl[i] <= '0;
        end else if (wr_en_i) begin
            note_tbl[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            dur_q   <= '0;
            div_q   <= '0;
            tick_q  <= '0;
            gap_q   <= '0;
            freq_q  <= '0;
            gate_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            dur_q   <= dur_d;
            div_q   <= div_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
            freq_q  <= freq_d;
            gate_q  <= gate_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        dur_d   = dur_q;
        div_d   = div_q;
        tick_d  = tick_q;
        gap_d   = gap_q;
        freq_d  = freq_q;
        gate_d  = gate_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    if (seq_len_i == 5'd0) begin
                        done_d = 1'b1;
                    end else begin
                        len_d = (seq_len_i > 5'd16) ? 5'd16 : seq_len_i;
                        load  = 1'b1;
                    end
                end
            end
            PLAY: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (tick_q == dur_q) begin
                        state_d = GAP;
                        freq_d  = '0;
                        gate_d  = 1'b0;
                        gap_d   = '0;
                    end else begin
                        tick_d = tick_q + 4'd1;
                    end
                end else begin
                    div_d = div_q + 20'd1;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (!last_entry) begin
                        load = 1'b1;
                    end else begin
`ifdef AUDIO_SEQ_LOOP_EN
                        load = 1'b1;
`else
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        idx_d   = '0;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = PLAY;
            idx_d   = fetch_idx;
            freq_d  = fetch_entry[15:0];
            gate_d  = |fetch_entry[15:0];
            dur_d   = fetch_entry[19:16];
            div_d   = '0;
            tick_d  = '0;
            gap_d   = '0;
            busy_d  = 1'b1;
        end

        // Abort overrides everything, including a start in the same cycle.
        if (stop_i) begin
            state_d = IDLE;
            idx_d   = '0;
            div_d   = '0;
            tick_d  = '0;
            gap_d   = '0;
            freq_d  = '0;
            gate_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    assign freq_o    = freq_q;
    assign gate_o    = gate_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign cur_idx_o = idx_q;

endmodule

// File: tb/tb_audio_note_seq.sv
// Testbench for audio_note_seq with TICK_DIV=4, GAP_CYCLES=2.
// Expected per-cycle output words are pushed into a scoreboard queue from a
// shadow copy of the note table and popped against the DUT each cycle.
module tb_audio_note_seq;

    localparam int TD = 4;
    localparam int GC = 2;

    logic        clk_i = 1'b0;
    logic        rstn_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [4:0]  seq_len_i = '0;
    logic        wr_en_i = 1'b0;
    logic [3:0]  wr_addr_i = '0;
    logic [19:0] wr_data_i = '0;
    logic [15:0] freq_o;
    logic        gate_o;
    logic        busy_o;
    logic        done_o;
    logic [3:0]  cur_idx_o;

    audio_note_seq #(.TICK_DIV(TD), .GAP_CYCLES(GC)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .start_i(start_i), .stop_i(stop_i),
        .seq_len_i(seq_len_i), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
        .wr_data_i(wr_data_i), .freq_o(freq_o), .gate_o(gate_o),
        .busy_o(busy_o), .done_o(done_o), .cur_idx_o(cur_idx_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] freq;
        logic        gate;
        logic        busy;
        logic        done;
        logic [3:0]  idx;
    } exp_t;

    typedef struct {
        logic [19:0] e0;
        logic [19:0] e1;
        logic [4:0]  len;
        bit          hold;
    } vec_t;

    exp_t        sb[$];
    logic [19:0] shadow [16];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic exp_t mk(input logic [15:0] f, input logic g, input logic b,
                                input logic d, input logic [3:0] i);
        exp_t e;
        e.freq = f; e.gate = g; e.busy = b; e.done = d; e.idx = i;
        return e;
    endfunction

    task automatic check(input string name, input exp_t e);
        exp_t a;
        a = mk(freq_o, gate_o, busy_o, done_o, cur_idx_o);
        n_cmp++;
        if (a !== e) begin
            n_err++;
            $display("FAIL %s t=%0t got freq=%h gate=%b busy=%b done=%b idx=%0d want freq=%h gate=%b busy=%b done=%b idx=%0d",
                     name, $time, a.freq, a.gate, a.busy, a.done, a.idx,
                     e.freq, e.gate, e.busy, e.done, e.idx);
        end
    endtask

    task automatic write_entry(input logic [3:0] a, input logic [19:0] d);
        @(posedge clk_i); #1;
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        @(posedge clk_i); #1;
        wr_en_i = 1'b0;
        shadow[a] = d;
    endtask

    // One entry: (dur+1)*TD sounding cycles, then GC silent cycles.
    task automatic push_entry(input int i);
        logic [15:0] f;
        int          d;
        f = shadow[i][15:0];
        d = int'(shadow[i][19:16]);
        repeat ((d + 1) * TD) sb.push_back(mk(f, f != 16'd0, 1'b1, 1'b0, 4'(i)));
        repeat (GC) sb.push_back(mk(16'd0, 1'b0, 1'b1, 1'b0, 4'(i)));
    endtask

    task automatic build(input int n);
        for (int i = 0; i < n; i++) push_entry(i);
        sb.push_back(mk(16'd0, 1'b0, 1'b0, 1'b1, 4'd0));
        sb.push_back(mk(16'd0, 1'b0, 1'b0, 1'b0, 4'd0));
    endtask

    task automatic drain(input string name);
        exp_t e;
        while (sb.size() > 0) begin
            @(negedge clk_i);
            e = sb.pop_front();
            check(name, e);
            if (e.done) start_i = 1'b0;
        end
    endtask

    task automatic play(input logic [4:0] len, input bit hold, input string name);
        build((len > 5'd16) ? 16 : int'(len));
        @(posedge clk_i); #1;
        start_i = 1'b1; seq_len_i = len;
        @(posedge clk_i); #1;
        if (!hold) start_i = 1'b0;
        drain(name);
    endtask

    task automatic idle_cycles(input int n, input string name);
        repeat (n) begin
            @(negedge clk_i);
            check(name, mk(16'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        end
    endtask

    vec_t vecs [6];

    initial begin
        vecs[0] = '{20'h10100, 20'h00200, 5'd2, 1'b0};
        vecs[1] = '{20'h00000, 20'h00000, 5'd1, 1'b0};
        vecs[2] = '{20'h31234, 20'h20000, 5'd2, 1'b0};
        vecs[3] = '{20'hF0ABC, 20'h00000, 5'd1, 1'b0};
        vecs[4] = '{20'h10100, 20'h00200, 5'd2, 1'b1};
        vecs[5] = '{20'h00001, 20'h1FFFF, 5'd2, 1'b0};
        for (int i = 0; i < 16; i++) shadow[i] = '0;

        #12;
        check("reset_hold", mk(16'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        @(negedge clk_i); rstn_i = 1'b1;
        idle_cycles(2, "reset_idle");

`ifdef AUDIO_SEQ_LOOP_EN
        // Wrap test: two full rounds then the start of a third, never done.
        write_entry(4'd0, 20'h10100);
        write_entry(4'd1, 20'h00200);
        push_entry(0); push_entry(1); push_entry(0); push_entry(1);
        repeat (3) sb.push_back(mk(16'h0100, 1'b1, 1'b1, 1'b0, 4'd0));
        @(posedge clk_i); #1;
        start_i = 1'b1; seq_len_i = 5'd2;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        drain("loop_wrap");
        @(posedge clk_i); #1;
        stop_i = 1'b1;
        @(posedge clk_i); #1;
        stop_i = 1'b0;
        idle_cycles(3, "loop_stop");
`else
        for (int v = 0; v < 6; v++) begin
            write_entry(4'd0, vecs[v].e0);
            write_entry(4'd1, vecs[v].e1);
            play(vecs[v].len, vecs[v].hold, vecs[v].hold ? "vec_hold" : "vec_play");
        end

        // Length clamp: 20 requested, 16 played.
        for (int i = 0; i < 16; i++) write_entry(4'(i), {4'(i % 2), 16'h1000 + 16'(i)});
        play(5'd20, 1'b0, "len_clamp");

        // Zero length: no playback, done one cycle later.
        play(5'd0, 1'b0, "len_zero");

        // Abort mid-note, then restart from full duration.
        write_entry(4'd0, 20'h10100);
        write_entry(4'd1, 20'h00200);
        @(posedge clk_i); #1;
        start_i = 1'b1; seq_len_i = 5'd2;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) begin
            @(negedge clk_i);
            check("pre_stop", mk(16'h0100, 1'b1, 1'b1, 1'b0, 4'd0));
        end
        @(posedge clk_i); #1;
        stop_i = 1'b1;
        @(posedge clk_i); #1;
        stop_i = 1'b0;
        idle_cycles(12, "after_stop");
        play(5'd1, 1'b0, "restart");

        // Start and stop together in IDLE.
        @(posedge clk_i); #1;
        start_i = 1'b1; stop_i = 1'b1; seq_len_i = 5'd1;
        @(posedge clk_i); #1;
        start_i = 1'b0; stop_i = 1'b0;
        idle_cycles(3, "start_stop_idle");

        // Start and stop together while playing.
        @(posedge clk_i); #1;
        start_i = 1'b1; seq_len_i = 5'd1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("pre_both", mk(16'h0100, 1'b1, 1'b1, 1'b0, 4'd0));
        @(posedge clk_i); #1;
        start_i = 1'b1; stop_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0; stop_i = 1'b0;
        idle_cycles(3, "start_stop_play");
`endif

        // Async reset mid-note: outputs drop without waiting for an edge.
        write_entry(4'd0, 20'h15555);
        @(posedge clk_i); #1;
        start_i = 1'b1; seq_len_i = 5'd1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("pre_reset", mk(16'h5555, 1'b1, 1'b1, 1'b0, 4'd0));
        #2 rstn_i = 1'b0;
        #1 check("reset_async", mk(16'd0, 1'b0, 1'b0, 1'b0, 4'd0));
        @(negedge clk_i); rstn_i = 1'b1;
        for (int i = 0; i < 16; i++) shadow[i] = '0;
        idle_cycles(3, "reset_nodone");

        // Cleared table: entry 0 is a rest.
        play(5'd1, 1'b0, "rest_after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout t=%0t got no finish want finish", $time);
        $fatal(1, "timeout");
    end

endmodule
